// File: rtl/spi_slave_sync.sv
// System-clocked SPI slave: synchronised pins, all four modes, valid/ready TX/RX words.
// Optional sticky ERR_OVR/ERR_UDR outputs when SPI_SLAVE_ERR_FLAGS_EN is defined.
module spi_slave_sync #(
    parameter int LEN_DATA  = 8,
    parameter bit CPOL      = 1'b0,
    parameter bit CPHA      = 1'b0,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                SCLK,
    input  logic                MOSI,
    input  logic                SS,
    output logic                MISO,
    input  logic [LEN_DATA-1:0] TX_DATA,
    input  logic                TX_VALID,
    output logic                TX_READY,
    output logic [LEN_DATA-1:0] RX_DATA,
    output logic                RX_VALID,
    input  logic                RX_READY,
    output logic                BUSY
`ifdef SPI_SLAVE_ERR_FLAGS_EN
    ,
    output logic                ERR_OVR,
    output logic                ERR_UDR
`endif
);

    localparam int CNT_W = $clog2(LEN_DATA);

    typedef enum logic [1:0] {IDLE, ARMED, ACTIVE} state_t;

    state_t              state_q, state_d;
    logic [1:0]          sclk_sync_q, mosi_sync_q, ss_sync_q;
    logic                sclk_prev_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [LEN_DATA-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
    logic [LEN_DATA-1:0] hold_q, hold_d, rx_data_q, rx_data_d;
    logic                hold_full_q, hold_full_d, rx_valid_q, rx_valid_d;
    logic                miso_q, miso_d;

    logic sclk_s, mosi_s, ss_s, lead_edge, trail_edge;
    logic in_word, do_sample, do_shift, word_done, do_load;
    logic [LEN_DATA-1:0] load_word, tx_shifted, rx_next;

    function automatic logic first_bit(input logic [LEN_DATA-1:0] w);
        return LSB_FIRST ? w[0] : w[LEN_DATA-1];
    endfunction

    assign sclk_s     = sclk_sync_q[1];
    assign mosi_s     = mosi_sync_q[1];
    assign ss_s       = ss_sync_q[1];
    assign lead_edge  = (sclk_prev_q == CPOL) && (sclk_s != CPOL);
    assign trail_edge = (sclk_prev_q != CPOL) && (sclk_s == CPOL);

    // NOTE: SS synchroniser resets low so a frame already running at reset release looks
    // "in progress" and IDLE keeps waiting for a genuine SS high before arming.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sclk_sync_q <= {2{CPOL}};
            mosi_sync_q <= 2'b00;
            ss_sync_q   <= 2'b00;
            sclk_prev_q <= CPOL;
        end else begin
            sclk_sync_q <= {sclk_sync_q[0], SCLK};
            mosi_sync_q <= {mosi_sync_q[0], MOSI};
            ss_sync_q   <= {ss_sync_q[0], SS};
            sclk_prev_q <= sclk_s;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ss_s)  state_d = ARMED;
            ARMED:   if (!ss_s) state_d = ACTIVE;
            ACTIVE:  if (ss_s)  state_d = ARMED;
            default:            state_d = IDLE;
        endcase
    end

    // In CPHA=0 the shift after the last sample is skipped: the next word is already on MISO.
    always_comb begin
        in_word   = (state_q == ACTIVE) && !ss_s;
        do_sample = in_word && (CPHA ? trail_edge : lead_edge);
        do_shift  = in_word && (CPHA ? lead_edge : trail_edge) && (CPHA || cnt_q != '0);
        word_done = do_sample && (cnt_q == CNT_W'(LEN_DATA - 1));
        do_load   = ((state_q == ARMED) && !ss_s) || word_done;
    end

    assign load_word  = hold_full_q ? hold_q : '1;
    assign tx_shifted = LSB_FIRST ? (tx_sh_q >> 1) : (tx_sh_q << 1);
    assign rx_next    = LSB_FIRST ? {mosi_s, rx_sh_q[LEN_DATA-1:1]}
                                  : {rx_sh_q[LEN_DATA-2:0], mosi_s};

    always_comb begin
        cnt_d       = cnt_q;
        tx_sh_d     = tx_sh_q;
        rx_sh_d     = rx_sh_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        miso_d      = miso_q;

        if (!in_word)       cnt_d = '0;
        else if (do_sample) cnt_d = word_done ? '0 : cnt_q + 1'b1;

        if (do_sample) rx_sh_d = rx_next;

        if (word_done) begin
            rx_data_d  = rx_next;
            rx_valid_d = 1'b1;
        end else if (rx_valid_q && RX_READY) begin
            rx_valid_d = 1'b0;
        end

        // A load sees the pre-accept holding state; a same-cycle accept refills it.
        if (do_load) hold_full_d = 1'b0;
        if (TX_VALID && !hold_full_q) begin
            hold_full_d = 1'b1;
            hold_d      = TX_DATA;
        end

        if (do_load)       tx_sh_d = load_word;
        else if (do_shift) tx_sh_d = tx_shifted;

        if (state_d != ACTIVE)    miso_d = 1'b1;
        else if (do_load && !CPHA) miso_d = first_bit(load_word);
        else if (do_shift)         miso_d = CPHA ? first_bit(tx_sh_q) : first_bit(tx_shifted);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop updates from pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q       <= '0;
            tx_sh_q     <= '1;
            rx_sh_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            miso_q      <= 1'b1;
        end else begin
            cnt_q       <= cnt_d;
            tx_sh_q     <= tx_sh_d;
            rx_sh_q     <= rx_sh_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            miso_q      <= miso_d;
        end
    end

    assign MISO     = miso_q;
    assign TX_READY = !hold_full_q;
    assign RX_DATA  = rx_data_q;
    assign RX_VALID = rx_valid_q;
    assign BUSY     = (state_q == ACTIVE);

`ifdef SPI_SLAVE_ERR_FLAGS_EN
    logic err_ovr_q, err_udr_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            err_ovr_q <= 1'b0;
            err_udr_q <= 1'b0;
        end else begin
            err_ovr_q <= err_ovr_q | (word_done && rx_valid_q && !RX_READY);
            err_udr_q <= err_udr_q | (do_load && !hold_full_q);
        end
    end

    assign ERR_OVR = err_ovr_q;
    assign ERR_UDR = err_udr_q;
`endif

endmodule

// File: tb/tb_spi_slave_sync.sv
// Directed bench for spi_slave_sync: instance 0 in mode 0 LSB-first, instance 1 in mode 3 MSB-first.
// Error-flag checks are compiled in when SPI_SLAVE_ERR_FLAGS_EN is defined.
module tb_spi_slave_sync;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk [2];
    logic       mosi [2];
    logic       ss [2];
    logic       miso [2];
    logic [7:0] tx_data [2];
    logic       tx_valid [2];
    logic       tx_ready [2];
    logic [7:0] rx_data [2];
    logic       rx_valid [2];
    logic       rx_ready [2];
    logic       busy [2];
`ifdef SPI_SLAVE_ERR_FLAGS_EN
    logic       err_ovr [2];
    logic       err_udr [2];
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] got;

    always #5 clk = ~clk;

    spi_slave_sync #(.LEN_DATA(8), .CPOL(1'b0), .CPHA(1'b0), .LSB_FIRST(1'b1)) dut0 (
        .CLK(clk), .RST_N(rst_n), .SCLK(sclk[0]), .MOSI(mosi[0]), .SS(ss[0]), .MISO(miso[0]),
        .TX_DATA(tx_data[0]), .TX_VALID(tx_valid[0]), .TX_READY(tx_ready[0]),
        .RX_DATA(rx_data[0]), .RX_VALID(rx_valid[0]), .RX_READY(rx_ready[0]), .BUSY(busy[0])
`ifdef SPI_SLAVE_ERR_FLAGS_EN
        , .ERR_OVR(err_ovr[0]), .ERR_UDR(err_udr[0])
`endif
    );

    spi_slave_sync #(.LEN_DATA(8), .CPOL(1'b1), .CPHA(1'b1), .LSB_FIRST(1'b0)) dut3 (
        .CLK(clk), .RST_N(rst_n), .SCLK(sclk[1]), .MOSI(mosi[1]), .SS(ss[1]), .MISO(miso[1]),
        .TX_DATA(tx_data[1]), .TX_VALID(tx_valid[1]), .TX_READY(tx_ready[1]),
        .RX_DATA(rx_data[1]), .RX_VALID(rx_valid[1]), .RX_READY(rx_ready[1]), .BUSY(busy[1])
`ifdef SPI_SLAVE_ERR_FLAGS_EN
        , .ERR_OVR(err_ovr[1]), .ERR_UDR(err_udr[1])
`endif
    );

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic half_period();
        repeat (4) @(negedge clk);
    endtask

    function automatic int bit_pos(input int i, input bit lsb);
        return (i / 8) * 8 + (lsb ? i % 8 : 7 - i % 8);
    endfunction

    task automatic check_reset_state(input string tag);
        for (int d = 0; d < 2; d++) begin
            check({tag, "_miso"}, 32'(miso[d]), 32'd1);
            check({tag, "_tx_ready"}, 32'(tx_ready[d]), 32'd1);
            check({tag, "_rx_valid"}, 32'(rx_valid[d]), 32'd0);
            check({tag, "_rx_data"}, 32'(rx_data[d]), 32'd0);
            check({tag, "_busy"}, 32'(busy[d]), 32'd0);
`ifdef SPI_SLAVE_ERR_FLAGS_EN
            check({tag, "_err_ovr"}, 32'(err_ovr[d]), 32'd0);
            check({tag, "_err_udr"}, 32'(err_udr[d]), 32'd0);
`endif
        end
    endtask

    task automatic tx_push(input int d, input logic [7:0] data);
        tx_data[d]  = data;
        tx_valid[d] = 1'b1;
        @(negedge clk);
        tx_valid[d] = 1'b0;
        check("tx_ready_after_push", 32'(tx_ready[d]), 32'd0);
    endtask

    task automatic rx_pop(input int d);
        rx_ready[d] = 1'b1;
        @(negedge clk);
        rx_ready[d] = 1'b0;
        check("rx_valid_after_pop", 32'(rx_valid[d]), 32'd0);
    endtask

    // Master side of one SS frame; d selects the instance (0: mode 0 LSB, 1: mode 3 MSB).
    task automatic spi_frame(input int d, input int nbits, input logic [15:0] mo,
                             input bit lat_chk, output logic [15:0] mi);
        bit cpol = (d != 0);
        bit cpha = (d != 0);
        bit lsb  = (d == 0);
        mi = '0;
        if (!cpha) mosi[d] = mo[bit_pos(0, lsb)];
        ss[d] = 1'b0;
        repeat (5) @(negedge clk);
        check("busy_in_frame", 32'(busy[d]), 32'd1);
        for (int i = 0; i < nbits; i++) begin
            if (!cpha) begin
                mi[bit_pos(i, lsb)] = miso[d];
                sclk[d] = ~cpol;
                if (lat_chk && i == nbits - 1) begin
                    repeat (2) @(posedge clk);
                    #1 check("rx_valid_lat2", 32'(rx_valid[d]), 32'd0);
                    @(posedge clk);
                    #1 check("rx_valid_lat3", 32'(rx_valid[d]), 32'd1);
                    repeat (2) @(negedge clk);
                end else begin
                    half_period();
                end
                sclk[d] = cpol;
                if (i < nbits - 1) mosi[d] = mo[bit_pos(i + 1, lsb)];
                half_period();
            end else begin
                sclk[d] = ~cpol;
                mosi[d] = mo[bit_pos(i, lsb)];
                half_period();
                mi[bit_pos(i, lsb)] = miso[d];
                sclk[d] = cpol;
                half_period();
            end
        end
        ss[d] = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            sclk[d]     = (d != 0);
            mosi[d]     = 1'b0;
            ss[d]       = 1'b1;
            tx_data[d]  = '0;
            tx_valid[d] = 1'b0;
            rx_ready[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Mode 0, LSB first: 0xA5 out, 0x3C in, RX_VALID three clocks after the 8th rising SCLK.
        tx_push(0, 8'hA5);
        spi_frame(0, 8, 16'h003C, 1'b1, got);
        check("m0_miso_word", 32'(got[7:0]), 32'hA5);
        check("m0_rx_data", 32'(rx_data[0]), 32'h3C);
        check("m0_rx_valid", 32'(rx_valid[0]), 32'd1);
        check("m0_tx_ready", 32'(tx_ready[0]), 32'd1);
        check("m0_miso_idle", 32'(miso[0]), 32'd1);
        check("m0_busy_idle", 32'(busy[0]), 32'd0);
        rx_pop(0);

        // Mode 3, MSB first: 0x81 out, 0xC3 in.
        tx_push(1, 8'h81);
        spi_frame(1, 8, 16'h00C3, 1'b0, got);
        check("m3_miso_word", 32'(got[7:0]), 32'h81);
        check("m3_rx_data", 32'(rx_data[1]), 32'hC3);
        check("m3_rx_valid", 32'(rx_valid[1]), 32'd1);

        // Underrun: two words without a TX preload, core reading every word.
        rx_ready[0] = 1'b1;
        spi_frame(0, 16, 16'h3412, 1'b0, got);
        rx_ready[0] = 1'b0;
        check("udr_miso_words", 32'(got), 32'hFFFF);
        check("udr_rx_data", 32'(rx_data[0]), 32'h34);
        check("udr_rx_valid", 32'(rx_valid[0]), 32'd0);
`ifdef SPI_SLAVE_ERR_FLAGS_EN
        check("udr_err_udr", 32'(err_udr[0]), 32'd1);
        check("udr_err_ovr", 32'(err_ovr[0]), 32'd0);
`endif

        // Overrun: 0x11 then 0x22 with RX_READY low.
        spi_frame(0, 16, 16'h2211, 1'b0, got);
        check("ovr_rx_data", 32'(rx_data[0]), 32'h22);
        check("ovr_rx_valid", 32'(rx_valid[0]), 32'd1);
`ifdef SPI_SLAVE_ERR_FLAGS_EN
        check("ovr_err_ovr", 32'(err_ovr[0]), 32'd1);
`endif
        rx_pop(0);

        // SS raised after 5 bits: partial word dropped, loaded TX word lost.
        tx_push(0, 8'h0F);
        spi_frame(0, 5, 16'h001F, 1'b0, got);
        check("part_miso_bits", 32'(got[4:0]), 32'h0F);
        check("part_rx_valid", 32'(rx_valid[0]), 32'd0);
        check("part_rx_data", 32'(rx_data[0]), 32'h22);
        check("part_tx_ready", 32'(tx_ready[0]), 32'd1);
        spi_frame(0, 8, 16'h005A, 1'b0, got);
        check("after_part_miso", 32'(got[7:0]), 32'hFF);
        check("after_part_rx_data", 32'(rx_data[0]), 32'h5A);
        check("after_part_rx_valid", 32'(rx_valid[0]), 32'd1);

        // Reset pulse mid-frame with SS held low: the frame must be ignored.
        ss[0] = 1'b0;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            sclk[0] = 1'b1; half_period();
            sclk[0] = 1'b0; half_period();
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_state("midrst_in");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_state("midrst_out");
        for (int i = 0; i < 8; i++) begin
            mosi[0] = i[0];
            sclk[0] = 1'b1; half_period();
            sclk[0] = 1'b0; half_period();
        end
        repeat (5) @(negedge clk);
        check("midrst_rx_valid", 32'(rx_valid[0]), 32'd0);
        check("midrst_busy", 32'(busy[0]), 32'd0);
        check("midrst_miso", 32'(miso[0]), 32'd1);
        ss[0] = 1'b1;
        repeat (5) @(negedge clk);
        spi_frame(0, 8, 16'h0066, 1'b0, got);
        check("midrst_next_miso", 32'(got[7:0]), 32'hFF);
        check("midrst_next_rx_data", 32'(rx_data[0]), 32'h66);
        check("midrst_next_rx_valid", 32'(rx_valid[0]), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
